bus_xfer_sequencer: RTL and testbench
=====================================

Name: bus_xfer_sequencer

Overview:
- Control stage directly upstream of the register file on the shared 16-bit bus.
- Accepts queued register-to-register transfer requests (source index, destination index) over a valid/ready handshake.
- Buffers requests and replays them one at a time as one-hot enable/latch strobes to the bus registers.
- Guarantees at most one bus driver per cycle.

Parameters:
- NREG, 10: number of bus registers. Index map is fixed in the package.
- IDX_W, 4: width of a register index.
- DEPTH, 4: request FIFO depth. Must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- step  in  1  advance qualifier; single-cycle pulse from clock_pulser. Tie high for free-run.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept a request.
- req_src  in  IDX_W  index of the register that drives the bus.
- req_dst  in  IDX_W  index of the register that captures the bus.
- enable  out  NREG  one-hot or zero; register output-enable strobes.
- latch  out  NREG  one-hot or zero; register capture strobes.
- busy  out  1  FSM not IDLE, or FIFO non-empty.
- err  out  1  sticky illegal-request flag.
- xfer_count  out  16  completed-transfer count (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO flushed; state goes to IDLE.
  - enable, latch, xfer_count = 0; err = 0; busy = 0.
  - req_ready = 0 during reset, 1 the first cycle after.
- Reset mid-transfer aborts the transfer. Strobes are 0 from the next cycle. No partial latch is replayed.
- Handshake:
  - A request is accepted on a clk edge where req_valid & req_ready.
  - req_ready = (count < DEPTH), computed from the registered count only. A pop in the same cycle does not raise ready.
  - Push is independent of step.
- Illegal request: req_src==req_dst, or either index >= NREG.
  - Still accepted (handshake completes).
  - Not enqueued; err set to 1 on that edge.
  - err clears only on reset.
- FSM states IDLE, DRIVE, CAPTURE. All state changes occur only on edges with step==1.
  - IDLE: if FIFO non-empty, pop the head, then go to DRIVE with enable[src]=1 and latch=0.
  - DRIVE: go to CAPTURE. enable[src] held, latch[dst]=1.
  - CAPTURE: completes the transfer.
    - If the FIFO is non-empty, pop and go to DRIVE with the new src; latch=0.
    - Else go to IDLE with enable=latch=0.
- Throughput: one transfer per 2 steps back-to-back. The first strobe appears 1 step after acceptance into an empty, idle sequencer.
- enable and latch are registered outputs; no combinational path from inputs to outputs.
- Push and pop in the same cycle: count is unchanged and ordering is preserved (FIFO order).
- FIFO pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- With step==0, all outputs hold their values indefinitely.

Optional Feature:
- Macro XFER_COUNT_EN.
- Defined: xfer_count increments by 1 on each step edge that leaves CAPTURE. Wraps 0xFFFF to 0x0000. Reset to 0.
- Undefined: counter logic is absent and xfer_count is tied to 16'h0000.

Decomposition:
- Package fpg8_bus_pkg holds:
  - Register index constants: GPR=0, MDR=1, IR=2, TIMER=3, CONROM=4, MAR=5, Y=6, Z=7, PSW=8, SCRATCH=9.
  - NREG_DEF=10 and IDX_W_DEF=4.
  - The FSM state encoding (IDLE=2'd0, DRIVE=2'd1, CAPTURE=2'd2).
- Sub-module xfer_fifo: synchronous FIFO of {src,dst}, width 2*IDX_W, with push/pop/count/full/empty. Same clk and active-low synchronous reset.

Test Plan:
- Reset then single request src=MDR(1), dst=IR(2), step tied high:
  - Edge 1 after accept: enable=10'h002, latch=0.
  - Edge 2: enable=10'h002, latch=10'h004.
  - Edge 3: both 0, busy=0.
- Push 4 requests with step=0:
  - req_ready=0 after the 4th.
  - A 5th req_valid is not accepted.
  - Then step high: transfers replay in order, 2 steps each, back-to-back with no IDLE gap. One-hot check on enable every cycle.
- Illegal requests src=3,dst=3 and src=12,dst=0:
  - Both accepted; err=1.
  - No strobes issued; busy stays 0.
  - A following legal request executes normally with err still 1.
- Assert reset during CAPTURE of request Y(6)->Z(7) with 2 requests queued:
  - Next cycle enable=latch=0, busy=0, FIFO empty, err=0.
  - After release, no replay occurs.
- Hold step=0 mid-DRIVE for 5 cycles: enable stays 10'h040, latch stays 0. Resume on the next step pulse.
- With XFER_COUNT_EN, 3 legal transfers give xfer_count=3. Force the counter to 16'hFFFF, then 1 transfer gives 16'h0000. Without the macro, it reads 0 throughout.

Source files
------------

// File: rtl/fpg8_bus_pkg.sv
// Shared constants for the fpg8 bus: register index map,
// default sizes and the transfer sequencer state encoding.
package fpg8_bus_pkg;

  localparam int NREG_DEF  = 10;
  localparam int IDX_W_DEF = 4;

  localparam logic [IDX_W_DEF-1:0] GPR     = 4'd0;
  localparam logic [IDX_W_DEF-1:0] MDR     = 4'd1;
  localparam logic [IDX_W_DEF-1:0] IR      = 4'd2;
  localparam logic [IDX_W_DEF-1:0] TIMER   = 4'd3;
  localparam logic [IDX_W_DEF-1:0] CONROM  = 4'd4;
  localparam logic [IDX_W_DEF-1:0] MAR     = 4'd5;
  localparam logic [IDX_W_DEF-1:0] Y       = 4'd6;
  localparam logic [IDX_W_DEF-1:0] Z       = 4'd7;
  localparam logic [IDX_W_DEF-1:0] PSW     = 4'd8;
  localparam logic [IDX_W_DEF-1:0] SCRATCH = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } xfer_state_e;

endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// Request handshake and register strobe bundle of the
// bus transfer sequencer.
interface bus_xfer_sequencer_if
  import fpg8_bus_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int IDX_W = IDX_W_DEF
);

  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_src;
  logic [IDX_W-1:0] req_dst;
  logic [NREG-1:0]  enable;
  logic [NREG-1:0]  latch;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, enable, latch
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, enable, latch
  );

endinterface

// File: rtl/bus_xfer_sequencer_fifo.sv
// Synchronous request FIFO holding {src,dst} pairs;
// pointers wrap naturally, count is one bit wider.
module xfer_fifo
  import fpg8_bus_pkg::*;
#(
  parameter int W     = 2 * IDX_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Replays queued register-to-register bus transfers as one-hot
// enable/latch strobes. Optional counter: define XFER_COUNT_EN.
module bus_xfer_sequencer
  import fpg8_bus_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  bus_xfer_sequencer_if.slave  bus,
  output logic                 busy,
  output logic                 err,
  output logic [15:0]          xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = 2 * IDX_W;

  xfer_state_e      state_q, state_d;
  logic [NREG-1:0]  en_q, en_d;
  logic [NREG-1:0]  la_q, la_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic             rdy_q;
  logic             pop;
  logic             accept;
  logic             legal;
  logic [W-1:0]     head;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  assign accept = bus.req_valid & bus.req_ready;
  assign legal  = (bus.req_src != bus.req_dst)
                & (int'(bus.req_src) < NREG)
                & (int'(bus.req_dst) < NREG);

  xfer_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept & legal),
    .pop   (pop),
    .din   ({bus.req_src, bus.req_dst}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  function automatic logic [NREG-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    return {{(NREG-1){1'b0}}, 1'b1} << i;
  endfunction

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    la_d    = la_q;
    dst_d   = dst_q;
    pop     = 1'b0;
    if (step) begin
      unique case (state_q)
        IDLE, CAPTURE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
            en_d    = onehot(head[W-1:IDX_W]);
            la_d    = '0;
            dst_d   = head[IDX_W-1:0];
          end else begin
            state_d = IDLE;
            en_d    = '0;
            la_d    = '0;
          end
        end
        DRIVE: begin
          state_d = CAPTURE;
          la_d    = onehot(dst_q);
        end
        default: begin
          state_d = IDLE;
          en_d    = '0;
          la_d    = '0;
        end
      endcase
    end
  end

  // ready is held low through reset and rises the cycle after
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= '0;
      la_q    <= '0;
      dst_q   <= '0;
      err     <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      la_q    <= la_d;
      dst_q   <= dst_d;
      err     <= err | (accept & ~legal);
      rdy_q   <= 1'b1;
    end
  end

  assign bus.req_ready = rdy_q & ~full;
  assign bus.enable    = en_q;
  assign bus.latch     = la_q;
  assign busy          = (state_q != IDLE) | (count != '0);

`ifdef XFER_COUNT_EN
  logic [15:0] xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)
      xfer_cnt_q <= '0;
    else if (step && state_q == CAPTURE)
      xfer_cnt_q <= xfer_cnt_q + 16'd1;
  end

  assign xfer_count = xfer_cnt_q;
`else
  assign xfer_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed bench for bus_xfer_sequencer: handshake, replay order,
// illegal requests, reset abort, step hold and transfer counter.
module tb_bus_xfer_sequencer;
  import fpg8_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic        busy;
  logic        err;
  logic [15:0] xfer_count;
  int          checks = 0;
  int          errors = 0;

  bus_xfer_sequencer_if #(.NREG(10), .IDX_W(4)) bus_if ();

  bus_xfer_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .bus        (bus_if),
    .busy       (busy),
    .err        (err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] d);
    bit done = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_src   = s;
    bus_if.req_dst   = d;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus_if.req_ready;
      tick();
    end
    bus_if.req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept src=%0d dst=%0d got ready=0 need 1",
               s, d);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step  = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_src   = '0;
    bus_if.req_dst   = '0;
    tick();
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch} !== 20'h0) begin
      errors++;
      $display("FAIL reset_strobes en=%h la=%h need 000 000",
               bus_if.enable, bus_if.latch);
    end
    checks++;
    if ({busy, err, bus_if.req_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags busy/err/ready=%b%b%b need 000",
               busy, err, bus_if.req_ready);
    end
    checks++;
    if (xfer_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_count got %h need 0000", xfer_count);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b need 1", bus_if.req_ready);
    end
  endtask

  task automatic test_single();
    step = 1'b1;
    push(MDR, IR);
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch} !== {10'h002, 10'h000}) begin
      errors++;
      $display("FAIL single_e1 en=%h la=%h need 002 000",
               bus_if.enable, bus_if.latch);
    end
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch} !== {10'h002, 10'h004}) begin
      errors++;
      $display("FAIL single_e2 en=%h la=%h need 002 004",
               bus_if.enable, bus_if.latch);
    end
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch, busy} !== 21'h0) begin
      errors++;
      $display("FAIL single_e3 en=%h la=%h busy=%b need 000 000 0",
               bus_if.enable, bus_if.latch, busy);
    end
  endtask

  task automatic test_fill();
    logic [3:0] src_t [4] = '{4'd1, 4'd6, 4'd9, 4'd5};
    logic [3:0] dst_t [4] = '{4'd2, 4'd7, 4'd0, 4'd4};
    logic [9:0] en_t  [4] = '{10'h002, 10'h040, 10'h200, 10'h020};
    logic [9:0] la_t  [4] = '{10'h004, 10'h080, 10'h001, 10'h010};
    bit         rdy_seen = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 4; i++) push(src_t[i], dst_t[i]);
    checks++;
    if (bus_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full ready=%b need 0", bus_if.req_ready);
    end
    bus_if.req_valid = 1'b1;
    bus_if.req_src   = 4'd3;
    bus_if.req_dst   = 4'd8;
    for (int i = 0; i < 3; i++) begin
      if (bus_if.req_ready !== 1'b0) rdy_seen = 1'b1;
      tick();
    end
    bus_if.req_valid = 1'b0;
    checks++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL fill_5th ready went 1 need 0 while full");
    end
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus_if.enable, bus_if.latch} !== {en_t[i], 10'h0}
          || $countones(bus_if.enable) != 1) begin
        errors++;
        $display("FAIL fill_drive%0d en=%h la=%h need %h 000",
                 i, bus_if.enable, bus_if.latch, en_t[i]);
      end
      tick();
      checks++;
      if ({bus_if.enable, bus_if.latch} !== {en_t[i], la_t[i]}
          || $countones(bus_if.enable) != 1) begin
        errors++;
        $display("FAIL fill_capt%0d en=%h la=%h need %h %h",
                 i, bus_if.enable, bus_if.latch, en_t[i], la_t[i]);
      end
    end
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch, busy} !== 21'h0) begin
      errors++;
      $display("FAIL fill_end en=%h la=%h busy=%b need 000 000 0",
               bus_if.enable, bus_if.latch, busy);
    end
  endtask

  task automatic test_illegal();
    bit quiet_bad = 1'b0;
    step = 1'b1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre err=%b need 0", err);
    end
    push(4'd3, 4'd3);
    push(4'd12, 4'd0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err err=%b need 1", err);
    end
    for (int i = 0; i < 4; i++) begin
      if ({bus_if.enable, bus_if.latch, busy} !== 21'h0)
        quiet_bad = 1'b1;
      tick();
    end
    checks++;
    if (quiet_bad) begin
      errors++;
      $display("FAIL illegal_quiet strobes/busy went nonzero need 0");
    end
    push(GPR, SCRATCH);
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch} !== {10'h001, 10'h000}) begin
      errors++;
      $display("FAIL illegal_next_e1 en=%h la=%h need 001 000",
               bus_if.enable, bus_if.latch);
    end
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch, err} !== {10'h001, 10'h200, 1'b1}) begin
      errors++;
      $display("FAIL illegal_next_e2 en=%h la=%h err=%b need 001 200 1",
               bus_if.enable, bus_if.latch, err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit replay = 1'b0;
    step = 1'b0;
    push(Y, Z);
    push(MDR, IR);
    push(IR, TIMER);
    step = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch} !== {10'h040, 10'h080}) begin
      errors++;
      $display("FAIL rstmid_capt en=%h la=%h need 040 080",
               bus_if.enable, bus_if.latch);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch, busy, err} !== 22'h0) begin
      errors++;
      $display("FAIL rstmid_abort en=%h la=%h busy=%b err=%b need 0",
               bus_if.enable, bus_if.latch, busy, err);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({bus_if.enable, bus_if.latch, busy} !== 21'h0) replay = 1'b1;
    end
    checks++;
    if (replay) begin
      errors++;
      $display("FAIL rstmid_replay strobes after reset need none");
    end
  endtask

  task automatic test_hold();
    bit moved = 1'b0;
    step = 1'b1;
    push(Y, Z);
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch} !== {10'h040, 10'h000}) begin
      errors++;
      $display("FAIL hold_drive en=%h la=%h need 040 000",
               bus_if.enable, bus_if.latch);
    end
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({bus_if.enable, bus_if.latch} !== {10'h040, 10'h000})
        moved = 1'b1;
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL hold_stall en=%h la=%h need 040 000",
               bus_if.enable, bus_if.latch);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch} !== {10'h040, 10'h080}) begin
      errors++;
      $display("FAIL hold_resume en=%h la=%h need 040 080",
               bus_if.enable, bus_if.latch);
    end
    step = 1'b1;
    tick();
    checks++;
    if ({bus_if.enable, bus_if.latch, busy} !== 21'h0) begin
      errors++;
      $display("FAIL hold_end en=%h la=%h busy=%b need 0",
               bus_if.enable, bus_if.latch, busy);
    end
  endtask

  task automatic test_count();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    step = 1'b0;
    push(MDR, IR);
    push(Y, Z);
    push(SCRATCH, GPR);
    step = 1'b1;
    for (int i = 0; i < 8; i++) tick();
`ifdef XFER_COUNT_EN
    checks++;
    if (xfer_count !== 16'd3) begin
      errors++;
      $display("FAIL count_three got %h need 0003", xfer_count);
    end
    step = 1'b0;
    force dut.xfer_cnt_q = 16'hFFFF;
    #1;
    release dut.xfer_cnt_q;
    push(MAR, CONROM);
    step = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (xfer_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_wrap got %h need 0000", xfer_count);
    end
`else
    checks++;
    if (xfer_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_off got %h need 0000", xfer_count);
    end
    push(MAR, CONROM);
    tick();
    tick();
    checks++;
    if (xfer_count !== 16'h0000) begin
      errors++;
      $display("FAIL count_off_mid got %h need 0000", xfer_count);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_reset_mid();
    test_hold();
    test_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
